pipe_control_unit: RTL and testbench

- Successor to the single-cycle combinational decoder: it decodes the MIPS instruction in ID, then carries the control bundle through three registered stages (S1=EX, S2=MEM, S3=WB).
- Adds per-stage valid bits, whole-pipe stall, ID bubble insertion (flush), a syscall-halt state machine and a retired-instruction counter.
- Sits between the IF/ID register and the datapath stage muxes of the pipelined CPU.

---
 rtl/pipe_control_unit.sv | 214 +++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control unit: decodes the ID instruction and carries the control
// bundle through EX/MEM/WB, with stall, flush, a syscall-halt FSM and a retire counter.
module pipe_control_unit #(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_CODE = 32'd10,
  parameter int          ALU_W     = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic [31:0]      in_is,
  input  logic             in_valid,
  input  logic [31:0]      in_v0,
  input  logic             in_stall,
  input  logic             in_flush,
  input  logic             in_go,
  output logic [ALU_W-1:0] out_ex_alumode,
  output logic             out_ex_im,
  output logic [5:0]       out_ex_br,
  output logic             out_ex_illegal,
  output logic             out_mem_write,
  output logic             out_mem_read,
  output logic             out_wb_regwrite,
  output logic [1:0]       out_wb_regdst,
  output logic             out_wb_memtoreg,
  output logic             out_stop,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_retired
);

  localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(7);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(8);
  localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(9);
  localparam logic [ALU_W-1:0] ALU_NOR  = ALU_W'(10);
  localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(11);
  localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(12);
  localparam logic [ALU_W-1:0] ALU_LUI  = ALU_W'(13);

  // A bubble is the all-zero bundle, so stage outputs need no extra gating.
  typedef struct packed {
    logic             valid;
    logic [ALU_W-1:0] alumode;
    logic             im;
    logic [5:0]       br;        // {J, JAL, JR, BEQ, BNE, BGEZ}
    logic             illegal;
    logic             mem_write;
    logic             mem_read;
    logic             regwrite;
    logic [1:0]       regdst;    // 0=rt, 1=rd, 2=$31
    logic             memtoreg;
    logic             halt;
  } ctrl_t;

  typedef enum logic [0:0] {RUN, HALTED} state_t;

  state_t state, state_next;
  ctrl_t  dec, s1_next, s1, s2, s3;
  logic   advance, release_s3;

  logic [5:0] op, funct;
  logic [4:0] rt;
  assign op    = in_is[31:26];
  assign funct = in_is[5:0];
  assign rt    = in_is[20:16];

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    dec = '0;
    unique case (op)
      6'h00: begin
        dec.regdst   = 2'd1;
        dec.regwrite = 1'b1;
        unique case (funct)
          6'h20, 6'h21: dec.alumode = ALU_ADD;
          6'h22, 6'h23: dec.alumode = ALU_SUB;
          6'h24:        dec.alumode = ALU_AND;
          6'h25:        dec.alumode = ALU_OR;
          6'h26:        dec.alumode = ALU_XOR;
          6'h27:        dec.alumode = ALU_NOR;
          6'h2A:        dec.alumode = ALU_SLT;
          6'h2B:        dec.alumode = ALU_SLTU;
          6'h00:        dec.alumode = ALU_SLL;
          6'h02:        dec.alumode = ALU_SRL;
          6'h03:        dec.alumode = ALU_SRA;
          6'h08: begin
            dec = '0;
            dec.br[3] = 1'b1;
          end
          6'h0C: begin
            dec = '0;
            dec.halt = (in_v0 == HALT_CODE);
          end
          default: begin
            dec = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec.im       = 1'b1;
        dec.regwrite = 1'b1;
        unique case (op)
          6'h0A:   dec.alumode = ALU_SLT;
          6'h0C:   dec.alumode = ALU_AND;
          6'h0D:   dec.alumode = ALU_OR;
          6'h0E:   dec.alumode = ALU_XOR;
          6'h0F:   dec.alumode = ALU_LUI;
          default: dec.alumode = ALU_ADD;
        endcase
      end
      6'h23: begin
        dec.alumode  = ALU_ADD;
        dec.im       = 1'b1;
        dec.mem_read = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
      end
      6'h2B: begin
        dec.alumode   = ALU_ADD;
        dec.im        = 1'b1;
        dec.mem_write = 1'b1;
      end
      6'h04: begin
        dec.alumode = ALU_SUB;
        dec.br[2]   = 1'b1;
      end
      6'h05: begin
        dec.alumode = ALU_SUB;
        dec.br[1]   = 1'b1;
      end
      6'h01: begin
        if (rt == 5'd1) dec.br[0] = 1'b1;
        else            dec.illegal = 1'b1;
      end
      6'h02: dec.br[5] = 1'b1;
      6'h03: begin
        dec.br[4]    = 1'b1;
        dec.regwrite = 1'b1;
        dec.regdst   = 2'd2;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.valid = 1'b1;
    if (!in_valid) dec = '0;
  end

  assign out_stop = (s1.valid & s1.halt) | (s2.valid & s2.halt) |
                    (s3.valid & s3.halt) | (state == HALTED);
  assign s1_next  = (in_flush || out_stop) ? '0 : dec;

  // Stall freezes everything, including a pending release from HALTED.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    release_s3 = 1'b0;
    if (!in_stall) begin
      unique case (state)
        RUN: begin
          advance = 1'b1;
          if (s3.valid && s3.halt) state_next = HALTED;
        end
        HALTED: begin
          if (in_go) begin
            state_next = RUN;
            release_s3 = 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) state <= RUN;
    else           state <= state_next;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      out_retired <= '0;
    end else if (advance) begin
      s1 <= s1_next;
      s2 <= s1;
      s3 <= s2;
      if (s3.valid) out_retired <= out_retired + CNT_W'(1);
    end else if (release_s3) begin
      s3 <= '0;
    end
  end

  assign out_ex_alumode  = s1.alumode;
  assign out_ex_im       = s1.im;
  assign out_ex_br       = s1.br;
  assign out_ex_illegal  = s1.illegal;
  assign out_mem_write   = s2.mem_write;
  assign out_mem_read    = s2.mem_read;
  assign out_wb_regwrite = s3.regwrite;
  assign out_wb_regdst   = s3.regdst;
  assign out_wb_memtoreg = s3.memtoreg;
  assign out_halted      = (state == HALTED);

  // Fields not consumed at a given stage only ride along.
  logic unused_bits;
  assign unused_bits = ^{in_is[25:21], in_is[15:6], s2, s3};

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: hand-computed expectations checked with
// immediate assertions; a second CNT_W=4 instance covers counter wrap.
module tb_pipe_control_unit;

  logic        in_clk = 1'b0;
  logic        in_rst_n, in_valid, in_stall, in_flush, in_go;
  logic [31:0] in_is, in_v0;

  logic [3:0]  ex_alumode, ex_alumode4;
  logic        ex_im, ex_im4;
  logic [5:0]  ex_br, ex_br4;
  logic        ex_illegal, ex_illegal4;
  logic        mem_write, mem_write4, mem_read, mem_read4;
  logic        wb_regwrite, wb_regwrite4;
  logic [1:0]  wb_regdst, wb_regdst4;
  logic        wb_memtoreg, wb_memtoreg4;
  logic        stop, stop4, halted, halted4;
  logic [31:0] retired;
  logic [3:0]  retired4;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] ADD_I  = 32'h0022_1820;
  localparam logic [31:0] LW_I   = 32'h8C43_0004;
  localparam logic [31:0] BEQ_I  = 32'h1022_0003;
  localparam logic [31:0] SYS_I  = 32'h0000_000C;
  localparam logic [31:0] ILL_I  = 32'hFC00_0000;

  always #5 in_clk = ~in_clk;

  pipe_control_unit dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_is(in_is), .in_valid(in_valid),
    .in_v0(in_v0), .in_stall(in_stall), .in_flush(in_flush), .in_go(in_go),
    .out_ex_alumode(ex_alumode), .out_ex_im(ex_im), .out_ex_br(ex_br),
    .out_ex_illegal(ex_illegal), .out_mem_write(mem_write), .out_mem_read(mem_read),
    .out_wb_regwrite(wb_regwrite), .out_wb_regdst(wb_regdst),
    .out_wb_memtoreg(wb_memtoreg), .out_stop(stop), .out_halted(halted),
    .out_retired(retired)
  );

  pipe_control_unit #(.CNT_W(4)) dut4 (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_is(in_is), .in_valid(in_valid),
    .in_v0(in_v0), .in_stall(in_stall), .in_flush(in_flush), .in_go(in_go),
    .out_ex_alumode(ex_alumode4), .out_ex_im(ex_im4), .out_ex_br(ex_br4),
    .out_ex_illegal(ex_illegal4), .out_mem_write(mem_write4), .out_mem_read(mem_read4),
    .out_wb_regwrite(wb_regwrite4), .out_wb_regdst(wb_regdst4),
    .out_wb_memtoreg(wb_memtoreg4), .out_stop(stop4), .out_halted(halted4),
    .out_retired(retired4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    in_rst_n = 1'b0; in_is = '0; in_valid = 1'b0; in_v0 = '0;
    in_stall = 1'b0; in_flush = 1'b0; in_go = 1'b0;
    tick(); tick();
    check("rst_alumode", 32'(ex_alumode), 32'd0);
    check("rst_br", 32'(ex_br), 32'd0);
    check("rst_regwrite", 32'(wb_regwrite), 32'd0);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", retired, 32'd0);

    // ADD: EX at +1, WB at +3, retired after the edge that leaves WB.
    in_rst_n = 1'b1; in_is = ADD_I; in_valid = 1'b1;
    tick();
    check("add_alumode", 32'(ex_alumode), 32'd5);
    check("add_im", 32'(ex_im), 32'd0);
    in_valid = 1'b0;
    tick(); tick();
    check("add_regwrite", 32'(wb_regwrite), 32'd1);
    check("add_regdst", 32'(wb_regdst), 32'd1);
    check("add_ret_pre", retired, 32'd0);
    tick();
    check("add_retired", retired, 32'd1);
    check("add_wb_gone", 32'(wb_regwrite), 32'd0);

    // LW held in MEM by a two-cycle stall.
    in_is = LW_I; in_valid = 1'b1;
    tick();
    check("lw_im", 32'(ex_im), 32'd1);
    in_valid = 1'b0;
    tick();
    check("lw_read0", 32'(mem_read), 32'd1);
    in_stall = 1'b1;
    tick();
    check("lw_read1", 32'(mem_read), 32'd1);
    tick();
    check("lw_read2", 32'(mem_read), 32'd1);
    check("lw_ret_stall", retired, 32'd1);
    in_stall = 1'b0;
    tick();
    check("lw_read_done", 32'(mem_read), 32'd0);
    check("lw_memtoreg", 32'(wb_memtoreg), 32'd1);
    check("lw_regdst", 32'(wb_regdst), 32'd0);
    tick();
    check("lw_retired", retired, 32'd2);

    // BEQ flushed to a bubble, then BEQ taken normally.
    in_is = BEQ_I; in_valid = 1'b1; in_flush = 1'b1;
    tick();
    check("beq_flush_br", 32'(ex_br), 32'd0);
    in_flush = 1'b0; in_valid = 1'b0;
    tick(); tick(); tick();
    check("beq_flush_ret", retired, 32'd2);
    in_valid = 1'b1;
    tick();
    check("beq_br", 32'(ex_br), 32'h04);
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("beq_retired", retired, 32'd3);

    // Illegal opcode: flagged in EX, no writes downstream.
    in_is = ILL_I; in_valid = 1'b1;
    tick();
    check("ill_flag", 32'(ex_illegal), 32'd1);
    in_valid = 1'b0;
    tick();
    check("ill_memwrite", 32'(mem_write), 32'd0);
    tick();
    check("ill_regwrite", 32'(wb_regwrite), 32'd0);
    tick();
    check("ill_retired", retired, 32'd4);

    // Syscall with $v0 != HALT_CODE does not stop fetch.
    in_is = SYS_I; in_v0 = 32'd3; in_valid = 1'b1;
    tick();
    check("sys3_stop", 32'(stop), 32'd0);
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("sys3_retired", retired, 32'd5);

    // Halting syscall followed by ADDs that must be dropped.
    in_v0 = 32'd10; in_valid = 1'b1;
    tick();
    check("halt_stop1", 32'(stop), 32'd1);
    in_is = ADD_I;
    tick();
    check("halt_drop_add", 32'(ex_alumode), 32'd0);
    tick();
    check("halt_not_yet", 32'(halted), 32'd0);
    tick();
    check("halt_entered", 32'(halted), 32'd1);
    check("halt_retired", retired, 32'd6);
    tick();
    check("halt_hold", 32'(halted), 32'd1);
    check("halt_stop_hold", 32'(stop), 32'd1);
    in_valid = 1'b0; in_go = 1'b1;
    tick();
    check("go_halted", 32'(halted), 32'd0);
    check("go_stop", 32'(stop), 32'd0);
    in_go = 1'b0;
    tick(); tick(); tick(); tick();
    check("go_no_retire", retired, 32'd6);

    // Counter wrap on the 4-bit instance: 17 retirements read back as 1.
    in_rst_n = 1'b0;
    tick();
    check("wrap_rst", 32'(retired4), 32'd0);
    in_rst_n = 1'b1; in_is = ADD_I; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("wrap_cnt4", 32'(retired4), 32'd1);
    check("wrap_cnt32", retired, 32'd17);

    // Reset mid-stream clears everything at the next edge.
    in_valid = 1'b1;
    tick(); tick();
    in_rst_n = 1'b0;
    tick();
    check("mid_rst_alumode", 32'(ex_alumode), 32'd0);
    check("mid_rst_retired", retired, 32'd0);
    check("mid_rst_stop", 32'(stop), 32'd0);
    check("mid_rst_mem", 32'(mem_read), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
